uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART receiver; downstream partner of uart_tx, consuming its TX line. Recovers 8N1-style
//   frames (1 start, DATA_WIDTH data LSB-first, 1 stop) from an asynchronous serial line by
//   mid-bit sampling. Presents each byte on a valid/ready handshake and flags framing and
//   overrun errors. Feeds the command/loopback logic that sits behind the UART.
// PARAMETERS
//   CLK_FREQ    50000000  system clock frequency, Hz
//   BAUDRATE    9600      line bit rate, bits/s; BIT_TICKS = CLK_FREQ/BAUDRATE (integer division)
//   DATA_WIDTH  8         data bits per frame, 1..15
// PORTS
//   clk        in   1           system clock; all logic on posedge
//   rst_n      in   1           reset, asynchronous, active-low
//   line       in   1           RX serial line, idle high, asynchronous to clk
//   data       out  DATA_WIDTH  received word; stable while valid=1
//   valid      out  1           data holds an unconsumed word
//   ready      in   1           consumer accepts data when valid&&ready at posedge
//   frame_err  out  1           1-cycle pulse: stop bit sampled low; frame discarded
//   overrun    out  1           1-cycle pulse: frame completed while valid=1; new word dropped
//   busy       out  1           1 in any state other than IDLE
// BEHAVIOUR
//   Reset: data=0, valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, sync flops=1'b1.
//   Input sync: 2-flop synchronizer on line -> rx_s; prev flop rx_d; fall = rx_d & ~rx_s.
//   Tick counter cnt: width clog2(BIT_TICKS); cleared on every state entry.
//   FSM:
//     IDLE : on fall -> START.
//     START: at cnt==BIT_TICKS/2-1 sample rx_s; 0 -> DATA (bit index 0), 1 -> IDLE (glitch,
//            no flags).
//     DATA : at cnt==BIT_TICKS-1 shift rx_s into shift reg at bit index (LSB first), clear cnt;
//            after bit DATA_WIDTH-1 -> STOP.
//     STOP : at cnt==BIT_TICKS-1 sample rx_s -> IDLE. 1: word complete; 0: frame_err=1 for
//            one cycle, word discarded, valid/data untouched.
//   Samples therefore fall at mid-bit (+2-cycle sync latency, constant across frame).
//   Word complete: if valid=0 or (valid&&ready same cycle) -> data<=shift reg, valid<=1 the
//     cycle after the stop sample. If valid=1 && !ready -> overrun=1 for one cycle, data kept.
//   Handshake: valid&&ready at posedge clears valid next cycle unless a word completes in that
//     same cycle (then valid stays 1, data replaced). ready ignored while valid=0.
//   Line held low (break): frame_err once; IDLE re-arms only on a new falling edge, so a
//     continuously low line produces no further frames.
//   Return to IDLE at stop sample (mid stop bit) so a back-to-back start edge is never missed.
//   rst_n low mid-frame: immediate abort, all outputs to reset values; a frame in flight at
//     deassertion is not recovered (resync on next falling edge after line high).
//   frame_err and overrun never assert in the same cycle (overrun only on good stop bit).
// TESTING  (sim params CLK_FREQ=160, BAUDRATE=10 -> BIT_TICKS=16; loopback from uart_tx)
//   Send 0xA5 with ready=1 -> valid pulses 1 cycle, data=0xA5; frame_err=overrun=0.
//   Send 0x00 then 0xFF back-to-back, ready=0 until both done -> data=0x00 held, overrun=1
//     once at second stop sample, after ready: data=0x00 consumed, valid=0.
//   Drive line low 4 cycles then high -> START aborts, busy returns 0, no valid/frame_err.
//   Frame 0x3C with stop bit forced 0 -> frame_err 1-cycle pulse, valid stays 0; hold line
//     low 100 cycles -> no second frame_err; release, send 0x81 -> data=0x81.
//   Assert rst_n low during bit 3 of 0x5A -> outputs reset asynchronously; release, send
//     0xC3 -> data=0xC3 exactly once.
//   BIT_TICKS skew: TX at +/-3% baud (BAUDRATE 9.7/10.3 equiv.) 0x55 -> received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with mid-bit sampling and a valid/ready output.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   line          : asynchronous serial input, idle high
//   data, valid   : received word and its "unconsumed" flag
//   ready         : consumer accepts data when valid && ready at posedge
//   frame_err     : 1-cycle pulse, stop bit sampled low (frame discarded)
//   overrun       : 1-cycle pulse, good frame finished while the previous word was pending
//   busy          : receiver is not idle
`timescale 1ns/1ps
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUDRATE   = 9600,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int unsigned BIT_TICKS = CLK_FREQ / BAUDRATE;
    localparam int unsigned CNT_W     = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
    localparam int unsigned IDX_W     = 4;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_TICKS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_TICKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  busy_q, busy_d;
    logic                  meta_q, rx_s_q, rx_d_q;
    logic                  fall;

    // Two-flop synchronizer plus one delay flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_d_q <= 1'b1;
        end else begin
            meta_q <= line;
            rx_s_q <= meta_q;
            rx_d_q <= rx_s_q;
        end
    end

    assign fall = rx_d_q & ~rx_s_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, sampling and handshake logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // A consumed word drops valid unless a new word lands in the same cycle (below).
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                // Mid start bit: a high line here was a glitch, drop silently.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (IDX_W'(i) == idx_q) begin
                            shift_d[i] = rx_s_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so an immediately following start edge is seen.
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        if (!valid_q || ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scenario-driven bench for uart_rx with a time-based serial line driver.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 160;
    localparam int unsigned BAUDRATE = 10;
    localparam real         BIT_NS   = 160.0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       line  = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Observed event history; tests take snapshots and compare deltas.
    int         valid_cyc = 0;
    int         fe_cnt    = 0;
    int         ov_cnt    = 0;
    int         rx_wr     = 0;
    logic [7:0] rx_mem [0:255];

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUDRATE  (BAUDRATE),
        .DATA_WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .line     (line),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) valid_cyc++;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (valid && ready) begin
                rx_mem[rx_wr[7:0]] = data;
                rx_wr++;
            end
        end
    end

    task automatic drive_bit(input logic b, input real per);
        line = b;
        #(per);
    endtask

    // Serial model of the transmitter: start, 8 data bits LSB first, stop.
    task automatic send_frame(input logic [7:0] b, input logic stop, input real per);
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(b[i], per);
        drive_bit(stop, per);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        line  = 1'b1;
        ready = 1'b0;
        idle_cycles(3);
        chk_cnt++; if (data !== 8'h00) $display("FAIL reset_data: got %h exp 00", data); else pass_cnt++;
        chk_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", valid); else pass_cnt++;
        chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b exp 0", frame_err); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b exp 0", overrun); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else pass_cnt++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle_cycles(5);
    endtask

    task automatic test_single;
        int v0, f0, o0, r0;
        v0 = valid_cyc; f0 = fe_cnt; o0 = ov_cnt; r0 = rx_wr;
        ready = 1'b1;
        send_frame(8'hA5, 1'b1, BIT_NS);
        idle_cycles(4);
        chk_cnt++; if (rx_wr - r0 !== 1) $display("FAIL single_count: got %0d exp 1", rx_wr - r0); else pass_cnt++;
        chk_cnt++; if (rx_mem[r0[7:0]] !== 8'hA5) $display("FAIL single_data: got %h exp a5", rx_mem[r0[7:0]]); else pass_cnt++;
        chk_cnt++; if (valid_cyc - v0 !== 1) $display("FAIL single_valid_width: got %0d exp 1", valid_cyc - v0); else pass_cnt++;
        chk_cnt++; if (fe_cnt - f0 !== 0) $display("FAIL single_frame_err: got %0d exp 0", fe_cnt - f0); else pass_cnt++;
        chk_cnt++; if (ov_cnt - o0 !== 0) $display("FAIL single_overrun: got %0d exp 0", ov_cnt - o0); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_idle: got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int f0, o0, r0;
        f0 = fe_cnt; o0 = ov_cnt; r0 = rx_wr;
        ready = 1'b0;
        send_frame(8'h00, 1'b1, BIT_NS);
        send_frame(8'hFF, 1'b1, BIT_NS);
        idle_cycles(4);
        chk_cnt++; if (ov_cnt - o0 !== 1) $display("FAIL b2b_overrun: got %0d exp 1", ov_cnt - o0); else pass_cnt++;
        chk_cnt++; if (fe_cnt - f0 !== 0) $display("FAIL b2b_frame_err: got %0d exp 0", fe_cnt - f0); else pass_cnt++;
        chk_cnt++; if (valid !== 1'b1) $display("FAIL b2b_valid_held: got %b exp 1", valid); else pass_cnt++;
        chk_cnt++; if (data !== 8'h00) $display("FAIL b2b_data_held: got %h exp 00", data); else pass_cnt++;
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        idle_cycles(2);
        chk_cnt++; if (rx_wr - r0 !== 1) $display("FAIL b2b_consumed_count: got %0d exp 1", rx_wr - r0); else pass_cnt++;
        chk_cnt++; if (rx_mem[r0[7:0]] !== 8'h00) $display("FAIL b2b_consumed_data: got %h exp 00", rx_mem[r0[7:0]]); else pass_cnt++;
        chk_cnt++; if (valid !== 1'b0) $display("FAIL b2b_valid_clear: got %b exp 0", valid); else pass_cnt++;
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = valid_cyc; f0 = fe_cnt;
        ready = 1'b1;
        @(posedge clk);
        #2 line = 1'b0;
        repeat (4) @(posedge clk);
        #2 line = 1'b1;
        @(negedge clk);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL glitch_busy_start: got %b exp 1", busy); else pass_cnt++;
        idle_cycles(20);
        chk_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_idle: got %b exp 0", busy); else pass_cnt++;
        chk_cnt++; if (valid_cyc - v0 !== 0) $display("FAIL glitch_valid: got %0d exp 0", valid_cyc - v0); else pass_cnt++;
        chk_cnt++; if (fe_cnt - f0 !== 0) $display("FAIL glitch_frame_err: got %0d exp 0", fe_cnt - f0); else pass_cnt++;
    endtask

    task automatic test_break;
        int v0, f0, r0;
        v0 = valid_cyc; f0 = fe_cnt; r0 = rx_wr;
        ready = 1'b1;
        send_frame(8'h3C, 1'b0, BIT_NS);
        idle_cycles(100);
        chk_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL break_frame_err: got %0d exp 1", fe_cnt - f0); else pass_cnt++;
        chk_cnt++; if (valid_cyc - v0 !== 0) $display("FAIL break_valid: got %0d exp 0", valid_cyc - v0); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL break_busy: got %b exp 0", busy); else pass_cnt++;
        line = 1'b1;
        idle_cycles(20);
        send_frame(8'h81, 1'b1, BIT_NS);
        idle_cycles(4);
        chk_cnt++; if (rx_wr - r0 !== 1) $display("FAIL break_recover_count: got %0d exp 1", rx_wr - r0); else pass_cnt++;
        chk_cnt++; if (rx_mem[r0[7:0]] !== 8'h81) $display("FAIL break_recover_data: got %h exp 81", rx_mem[r0[7:0]]); else pass_cnt++;
        chk_cnt++; if (fe_cnt - f0 !== 1) $display("FAIL break_single_err: got %0d exp 1", fe_cnt - f0); else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b;
        int         r0;
        b     = 8'h5A;
        ready = 1'b0;
        send_frame(8'h77, 1'b1, BIT_NS);
        idle_cycles(4);
        chk_cnt++; if (valid !== 1'b1) $display("FAIL rstmid_pending_valid: got %b exp 1", valid); else pass_cnt++;
        drive_bit(1'b0, BIT_NS);
        for (int i = 0; i < 3; i++) drive_bit(b[i], BIT_NS);
        line = b[3];
        #(BIT_NS / 2.0);
        @(posedge clk);
        #2;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b exp 1", busy); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        chk_cnt++; if (valid !== 1'b0) $display("FAIL rstmid_valid: got %b exp 0", valid); else pass_cnt++;
        chk_cnt++; if (data !== 8'h00) $display("FAIL rstmid_data: got %h exp 00", data); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b exp 0", busy); else pass_cnt++;
        #(BIT_NS / 2.0);
        for (int i = 4; i < 8; i++) drive_bit(b[i], BIT_NS);
        drive_bit(1'b1, BIT_NS);
        @(posedge clk);
        #2 rst_n = 1'b1;
        ready = 1'b1;
        idle_cycles(10);
        r0 = rx_wr;
        send_frame(8'hC3, 1'b1, BIT_NS);
        idle_cycles(40);
        chk_cnt++; if (rx_wr - r0 !== 1) $display("FAIL rstmid_count: got %0d exp 1", rx_wr - r0); else pass_cnt++;
        chk_cnt++; if (rx_mem[r0[7:0]] !== 8'hC3) $display("FAIL rstmid_data_after: got %h exp c3", rx_mem[r0[7:0]]); else pass_cnt++;
    endtask

    task automatic test_skew;
        real per [2];
        int  r0;
        per[0] = BIT_NS / 1.03;
        per[1] = BIT_NS / 0.97;
        ready  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            r0 = rx_wr;
            send_frame(8'h55, 1'b1, per[k]);
            idle_cycles(6);
            chk_cnt++; if (rx_wr - r0 !== 1) $display("FAIL skew%0d_count: got %0d exp 1", k, rx_wr - r0); else pass_cnt++;
            chk_cnt++; if (rx_mem[r0[7:0]] !== 8'h55) $display("FAIL skew%0d_data: got %h exp 55", k, rx_mem[r0[7:0]]); else pass_cnt++;
        end
    endtask

    // Random words with a consumer that always keeps up: every word must arrive, in order.
    task automatic test_random;
        logic [7:0] exp_q [$];
        int         r0, f0, o0;
        logic [7:0] b;
        r0 = rx_wr; f0 = fe_cnt; o0 = ov_cnt;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1, BIT_NS);
            idle_cycles(int'($urandom_range(0, 20)));
        end
        idle_cycles(6);
        chk_cnt++; if (rx_wr - r0 !== exp_q.size()) $display("FAIL rand_count: got %0d exp %0d", rx_wr - r0, exp_q.size()); else pass_cnt++;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk_cnt++;
            if (rx_mem[8'(r0 + i)] !== exp_q[i]) $display("FAIL rand_data%0d: got %h exp %h", i, rx_mem[8'(r0 + i)], exp_q[i]);
            else pass_cnt++;
        end
        chk_cnt++; if (fe_cnt - f0 + ov_cnt - o0 !== 0) $display("FAIL rand_errors: got %0d exp 0", fe_cnt - f0 + ov_cnt - o0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_skew();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
